mem_arb_2r1w: RTL and testbench

MEM_ARB_2R1W -- requirements
Module: mem_arb_2r1w

---
 rtl/mem_arb_2r1w.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arb_2r1w.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_2r1w.sv
// Two-requester (fetch + data) arbiter in front of a single-port RAM with fixed
// read latency; one transaction in flight, round-robin on contention.
module mem_arb_2r1w #(
    parameter int unsigned RAM_LAT   = 1,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [63:0] i_req_addr,
    output logic        i_resp_valid,
    output logic [31:0] i_resp_data,
    output logic        i_resp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [63:0] d_req_addr,
    input  logic        d_req_wen,
    input  logic [63:0] d_req_wdata,
    input  logic [63:0] d_req_wmask,
    output logic        d_resp_valid,
    output logic [63:0] d_resp_rdata,
    output logic        d_resp_err,
    output logic        ram_en,
    output logic [63:0] ram_idx,
    output logic        ram_wen,
    output logic [63:0] ram_wdata,
    output logic [63:0] ram_wmask,
    input  logic [63:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [3:0] LAST_CNT = 4'(RAM_LAT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_is_d_q, last_is_d_d;
    logic        src_is_d_q, src_is_d_d;
    logic [63:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] wmask_q, wmask_d;
    logic        err_q, err_d;
    logic [63:0] rdata_q, rdata_d;

    logic        gnt_i_s, gnt_d_s;
    logic        i_bad_s, d_bad_s;
    logic [63:0] offset_s;

    assign i_bad_s  = (i_req_addr < BASE_ADDR) || (i_req_addr[1:0] != 2'b00);
    assign d_bad_s  = (d_req_addr < BASE_ADDR) || (d_req_addr[2:0] != 3'b000);
    assign offset_s = addr_q - BASE_ADDR;

    // Grant: ready is withheld while reset is asserted so nothing is accepted then.
    always_comb begin
        gnt_i_s = 1'b0;
        gnt_d_s = 1'b0;
        if (rst_n && (state_q == IDLE)) begin
            if (i_req_valid && d_req_valid) begin
                gnt_i_s = last_is_d_q;
                gnt_d_s = !last_is_d_q;
            end else begin
                gnt_i_s = i_req_valid;
                gnt_d_s = d_req_valid;
            end
        end else begin
            gnt_i_s = 1'b0;
            gnt_d_s = 1'b0;
        end
    end

    // Next-state and transaction capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_is_d_d = last_is_d_q;
        src_is_d_d  = src_is_d_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_i_s) begin
                    last_is_d_d = 1'b0;
                    src_is_d_d  = 1'b0;
                    addr_d      = i_req_addr;
                    wen_d       = 1'b0;
                    wdata_d     = 64'd0;
                    wmask_d     = 64'd0;
                    err_d       = i_bad_s;
                    rdata_d     = 64'd0;
                    state_d     = i_bad_s ? RESP : ISSUE;
                end else if (gnt_d_s) begin
                    last_is_d_d = 1'b1;
                    src_is_d_d  = 1'b1;
                    addr_d      = d_req_addr;
                    wen_d       = d_req_wen;
                    wdata_d     = d_req_wdata;
                    wmask_d     = d_req_wmask;
                    err_d       = d_bad_s;
                    rdata_d     = 64'd0;
                    state_d     = d_bad_s ? RESP : ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = 4'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 4'd0;
                    rdata_d = ram_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and transaction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_is_d_q <= 1'b0;
            src_is_d_q  <= 1'b0;
            addr_q      <= 64'd0;
            wen_q       <= 1'b0;
            wdata_q     <= 64'd0;
            wmask_q     <= 64'd0;
            err_q       <= 1'b0;
            rdata_q     <= 64'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_is_d_q <= last_is_d_d;
            src_is_d_q  <= src_is_d_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    // Outputs decode straight from the state register, so async reset clears them at once.
    always_comb begin
        i_req_ready  = gnt_i_s;
        d_req_ready  = gnt_d_s;
        ram_en       = 1'b0;
        ram_wen      = 1'b0;
        ram_idx      = 64'd0;
        ram_wdata    = 64'd0;
        ram_wmask    = 64'd0;
        i_resp_valid = 1'b0;
        i_resp_err   = 1'b0;
        i_resp_data  = 32'd0;
        d_resp_valid = 1'b0;
        d_resp_err   = 1'b0;
        d_resp_rdata = 64'd0;
        if (state_q == ISSUE) begin
            ram_en    = 1'b1;
            ram_wen   = src_is_d_q && wen_q;
            ram_idx   = offset_s >> 3;
            ram_wdata = wdata_q;
            ram_wmask = wmask_q;
        end else if (state_q == RESP) begin
            if (src_is_d_q) begin
                d_resp_valid = 1'b1;
                d_resp_err   = err_q;
                d_resp_rdata = (err_q || wen_q) ? 64'd0 : rdata_q;
            end else begin
                i_resp_valid = 1'b1;
                i_resp_err   = err_q;
                i_resp_data  = err_q ? 32'd0 : (addr_q[2] ? rdata_q[63:32] : rdata_q[31:0]);
            end
        end else begin
            ram_en = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arb_2r1w.sv
// Bench for mem_arb_2r1w: instance A (RAM_LAT=1) and instance B (RAM_LAT=4) share
// a behavioural RAM; expected RAM accesses and responses are queued at accept time.
module tb_mem_arb_2r1w;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_iv, a_ir, a_irv, a_ie, a_dv, a_dr, a_dwen, a_drv, a_de, a_en, a_wen;
    logic [63:0] a_ia, a_da, a_dwd, a_dwm, a_drd, a_idx, a_wd, a_wm, a_rd;
    logic [31:0] a_ird;
    logic        b_iv, b_ir, b_irv, b_ie, b_dv, b_dr, b_dwen, b_drv, b_de, b_en, b_wen;
    logic [63:0] b_ia, b_da, b_dwd, b_dwm, b_drd, b_idx, b_wd, b_wm, b_rd;
    logic [31:0] b_ird;

    mem_arb_2r1w #(.RAM_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(a_iv), .i_req_ready(a_ir), .i_req_addr(a_ia),
        .i_resp_valid(a_irv), .i_resp_data(a_ird), .i_resp_err(a_ie),
        .d_req_valid(a_dv), .d_req_ready(a_dr), .d_req_addr(a_da), .d_req_wen(a_dwen),
        .d_req_wdata(a_dwd), .d_req_wmask(a_dwm),
        .d_resp_valid(a_drv), .d_resp_rdata(a_drd), .d_resp_err(a_de),
        .ram_en(a_en), .ram_idx(a_idx), .ram_wen(a_wen), .ram_wdata(a_wd),
        .ram_wmask(a_wm), .ram_rdata(a_rd)
    );

    mem_arb_2r1w #(.RAM_LAT(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(b_iv), .i_req_ready(b_ir), .i_req_addr(b_ia),
        .i_resp_valid(b_irv), .i_resp_data(b_ird), .i_resp_err(b_ie),
        .d_req_valid(b_dv), .d_req_ready(b_dr), .d_req_addr(b_da), .d_req_wen(b_dwen),
        .d_req_wdata(b_dwd), .d_req_wmask(b_dwm),
        .d_resp_valid(b_drv), .d_resp_rdata(b_drd), .d_resp_err(b_de),
        .ram_en(b_en), .ram_idx(b_idx), .ram_wen(b_wen), .ram_wdata(b_wd),
        .ram_wmask(b_wm), .ram_rdata(b_rd)
    );

    typedef struct { bit src_d; logic [63:0] data; bit err; int cyc; } resp_t;
    typedef struct { int cyc; logic [63:0] idx; bit wen; logic [63:0] wd; logic [63:0] wm; } ram_t;

    resp_t       resp_q [2][$];
    ram_t        ram_q  [2][$];
    logic [63:0] mem    [16];
    logic [63:0] pipe_b [4];
    bit          hs     [4];
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [63:0] init_word(input int k);
        logic [63:0] w;
        w = {32'hC0DE_0000 + 32'(k), 32'h0000_F000 + 32'(k)};
        if (k == 0) w = 64'hDEAD_BEEF_1234_5678;
        return w;
    endfunction

    function automatic int pending();
        return resp_q[0].size() + resp_q[1].size() + ram_q[0].size() + ram_q[1].size();
    endfunction

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_req(input int s, input bit src_d, input logic [63:0] addr,
                              input bit wen, input logic [63:0] wd, input logic [63:0] wm);
        resp_t r;
        ram_t  m;
        bit    err;
        logic [63:0] w;
        err   = (addr < BASE) || (src_d ? (addr[2:0] != 3'b000) : (addr[1:0] != 2'b00));
        m.idx = (addr - BASE) >> 3;
        w     = mem[m.idx[3:0]];
        r.src_d = src_d;
        r.err   = err;
        if (err)        r.data = 64'd0;
        else if (src_d) r.data = wen ? 64'd0 : w;
        else            r.data = addr[2] ? {32'd0, w[63:32]} : {32'd0, w[31:0]};
        r.cyc = cyc + (err ? 1 : 2 + ((s == 0) ? 1 : 4));
        resp_q[s].push_back(r);
        if (!err) begin
            m.cyc = cyc + 1;
            m.wen = src_d && wen;
            m.wd  = wd;
            m.wm  = wm;
            ram_q[s].push_back(m);
        end
    endtask

    task automatic check_dut(input int s, input logic en, input logic wen, input logic [63:0] idx,
                             input logic [63:0] wd, input logic [63:0] wm,
                             input logic iv, input logic [31:0] id, input logic ie,
                             input logic dv, input logic [63:0] dd, input logic de);
        string p;
        ram_t  m;
        resp_t r;
        p = (s == 0) ? "a" : "b";
        if (en) begin
            if (ram_q[s].size() == 0) cmp({p, "_ram_en_unexpected"}, en, 1'b0);
            else begin
                m = ram_q[s].pop_front();
                cmp({p, "_ram_en_cycle"}, cyc, m.cyc);
                cmp({p, "_ram_idx"}, idx, m.idx);
                cmp({p, "_ram_wen"}, wen, m.wen);
                if (m.wen) begin
                    cmp({p, "_ram_wdata"}, wd, m.wd);
                    cmp({p, "_ram_wmask"}, wm, m.wm);
                end
            end
        end else cmp({p, "_ram_wen_idle"}, wen, 1'b0);
        if (iv) begin
            if (resp_q[s].size() == 0 || resp_q[s][0].src_d) cmp({p, "_i_resp_unexpected"}, iv, 1'b0);
            else begin
                r = resp_q[s].pop_front();
                cmp({p, "_i_resp_cycle"}, cyc, r.cyc);
                cmp({p, "_i_resp_data"}, id, r.data);
                cmp({p, "_i_resp_err"}, ie, r.err);
            end
        end else cmp({p, "_i_resp_idle_zero"}, {id, ie}, 64'd0);
        if (dv) begin
            if (resp_q[s].size() == 0 || !resp_q[s][0].src_d) cmp({p, "_d_resp_unexpected"}, dv, 1'b0);
            else begin
                r = resp_q[s].pop_front();
                cmp({p, "_d_resp_cycle"}, cyc, r.cyc);
                cmp({p, "_d_resp_data"}, dd, r.data);
                cmp({p, "_d_resp_err"}, de, r.err);
            end
        end else cmp({p, "_d_resp_idle_zero"}, dd | {63'd0, de}, 64'd0);
    endtask

    // One clock: record handshakes, model the RAM across the edge, then check outputs.
    task automatic step();
        logic ae, aw, be;
        logic [63:0] ai, awd, awm, bi;
        #1;
        hs[0] = a_iv && a_ir;
        hs[1] = a_dv && a_dr;
        hs[2] = b_iv && b_ir;
        hs[3] = b_dv && b_dr;
        if (hs[0]) expect_req(0, 1'b0, a_ia, 1'b0, 64'd0, 64'd0);
        if (hs[1]) expect_req(0, 1'b1, a_da, a_dwen, a_dwd, a_dwm);
        if (hs[2]) expect_req(1, 1'b0, b_ia, 1'b0, 64'd0, 64'd0);
        if (hs[3]) expect_req(1, 1'b1, b_da, b_dwen, b_dwd, b_dwm);
        ae = a_en; aw = a_wen; ai = a_idx; awd = a_wd; awm = a_wm;
        be = b_en; bi = b_idx;
        @(posedge clk);
        cyc++;
        #1;
        if (ae && aw) mem[ai[3:0]] = (mem[ai[3:0]] & ~awm) | (awd & awm);
        a_rd = ae ? mem[ai[3:0]] : 64'd0;
        for (int k = 3; k > 0; k--) pipe_b[k] = pipe_b[k-1];
        pipe_b[0] = be ? mem[bi[3:0]] : 64'd0;
        b_rd = pipe_b[3];
        @(negedge clk);
        check_dut(0, a_en, a_wen, a_idx, a_wd, a_wm, a_irv, a_ird, a_ie, a_drv, a_drd, a_de);
        check_dut(1, b_en, b_wen, b_idx, b_wd, b_wm, b_irv, b_ird, b_ie, b_drv, b_drd, b_de);
    endtask

    task automatic send(input int port, input logic [63:0] addr, input logic wen,
                        input logic [63:0] wd, input logic [63:0] wm);
        case (port)
            0: begin a_iv = 1'b1; a_ia = addr; end
            1: begin a_dv = 1'b1; a_da = addr; a_dwen = wen; a_dwd = wd; a_dwm = wm; end
            2: begin b_iv = 1'b1; b_ia = addr; end
            default: begin b_dv = 1'b1; b_da = addr; b_dwen = wen; b_dwd = wd; b_dwm = wm; end
        endcase
        hs[port] = 1'b0;
        for (int k = 0; k < 20 && !hs[port]; k++) step();
        cmp("request_accepted", hs[port], 1'b1);
        case (port)
            0: a_iv = 1'b0;
            1: a_dv = 1'b0;
            2: b_iv = 1'b0;
            default: b_dv = 1'b0;
        endcase
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && pending() > 0; k++) step();
        cmp("drain_outstanding", pending(), 0);
    endtask

    initial begin
        int order;
        int di;
        int ii;
        for (int k = 0; k < 16; k++) mem[k] = init_word(k);
        for (int k = 0; k < 4; k++) pipe_b[k] = 64'd0;
        a_rd = 64'd0; b_rd = 64'd0;
        a_dwen = 1'b0; a_dwd = 64'd0; a_dwm = 64'd0;
        b_iv = 1'b0; b_ia = 64'd0; b_dv = 1'b0; b_da = 64'd0;
        b_dwen = 1'b0; b_dwd = 64'd0; b_dwm = 64'd0;
        // Both requesters valid while reset is held: nothing may be granted.
        rst_n = 1'b0;
        a_iv = 1'b1; a_ia = 64'h8000_0000;
        a_dv = 1'b1; a_da = 64'h8000_0008;
        @(negedge clk);
        cmp("reset_i_ready", a_ir, 1'b0);
        cmp("reset_d_ready", a_dr, 1'b0);
        cmp("reset_ram_en", a_en, 1'b0);
        cmp("reset_ram_wen", a_wen, 1'b0);
        cmp("reset_resp_valid", {a_irv, a_drv, b_irv, b_drv}, 64'd0);
        cmp("reset_resp_data", {a_ird, a_ie, a_de}, 64'd0);
        step();
        rst_n = 1'b1;

        // Contention from reset: grants d, i, d, i.
        order = 0; di = 0; ii = 0;
        for (int k = 0; k < 60 && (a_iv || a_dv); k++) begin
            step();
            if (k == 0) cmp("accept_first_cycle_after_reset", hs[1], 1'b1);
            if (hs[0] || hs[1]) begin
                cmp("grant_order", hs[1], (order % 2) == 0);
                order++;
            end
            if (hs[1]) begin di++; if (di == 2) a_dv = 1'b0; else a_da = 64'h8000_0018; end
            if (hs[0]) begin ii++; if (ii == 2) a_iv = 1'b0; else a_ia = 64'h8000_0004; end
        end
        cmp("contention_grant_count", order, 4);
        drain();

        // Fetch, full write, readback, masked write, upper-word fetch.
        send(0, 64'h8000_0004, 1'b0, 64'd0, 64'd0); drain();
        send(1, 64'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, ONES); drain();
        cmp("ram_after_write", mem[2], 64'h1122_3344_5566_7788);
        send(1, 64'h8000_0010, 1'b0, 64'd0, 64'd0); drain();
        send(1, 64'h8000_0010, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0000_0000_FFFF_FFFF); drain();
        cmp("ram_after_masked_write", mem[2], 64'h1122_3344_AAAA_AAAA);
        send(0, 64'h8000_0014, 1'b0, 64'd0, 64'd0); drain();

        // Erroneous requests: below base, misaligned.
        send(1, 64'h7FFF_FFF8, 1'b0, 64'd0, 64'd0); drain();
        send(0, 64'h8000_0002, 1'b0, 64'd0, 64'd0); drain();
        send(1, 64'h8000_0004, 1'b0, 64'd0, 64'd0); drain();
        send(0, 64'h7FFF_FFFC, 1'b0, 64'd0, 64'd0); drain();

        // Reset during ISSUE of a write: RAM strobes drop at once, no response.
        send(1, 64'h8000_0020, 1'b1, 64'h5555_5555_5555_5555, ONES);
        rst_n = 1'b0;
        #1;
        cmp("midreset_ram_en", a_en, 1'b0);
        cmp("midreset_ram_wen", a_wen, 1'b0);
        resp_q[0].delete();
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step();
        cmp("midreset_no_write", mem[4], init_word(4));
        send(0, 64'h8000_0000, 1'b0, 64'd0, 64'd0); drain();

        // RAM_LAT=4: response at N+6, ready low N+1..N+6 with a second request waiting.
        b_iv = 1'b1; b_ia = 64'h8000_0004;
        hs[2] = 1'b0;
        for (int k = 0; k < 20 && !hs[2]; k++) step();
        cmp("lat4_accept", hs[2], 1'b1);
        b_ia = 64'h8000_0008;
        for (int k = 0; k < 6; k++) begin
            cmp("lat4_ready_busy", b_ir, 1'b0);
            step();
        end
        cmp("lat4_ready_after_resp", b_ir, 1'b1);
        step();
        b_iv = 1'b0;
        drain();

        cmp("final_outstanding", pending(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
